spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave.sv | 153 +++++++++++++++
 tb/tb_spi_slave.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// SPI slave, all four CPOL/CPHA modes, selectable bit order, DATA_W-bit words.
// SPI pins are oversampled by clk_i through 2-flop synchronizers plus a history flop.
module spi_slave #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] tx_i,
    input  logic              tx_load_i,
    output logic [DATA_W-1:0] rx_o,
    output logic              irq_o,
    input  logic              ack_i,
    output logic              overrun_o,
    output logic              busy_o,
    input  logic              cpol_i,
    input  logic              dord_i,
    input  logic              cpha_i,
    input  logic              sclk_i,
    input  logic              ss_n_i,
    input  logic              mosi_i,
    output logic              miso_o,
    output logic              miso_en_o
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t state, state_nx;

    logic sclk_s1, sclk_s2, sclk_d;
    logic ss_s1, ss_s2, ss_d;
    logic mosi_s1, mosi_s2, mosi_d;

    logic [DATA_W-1:0] tx_r;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rx_sr;
    logic [CNT_W-1:0]  cnt;

    logic sclk_edge, lead_edge, trail_edge;
    logic ss_fall, start, abort, active;
    logic sample_ev, shift_ev, word_done;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sclk_s1 <= cpol_i;
            sclk_s2 <= cpol_i;
            sclk_d  <= cpol_i;
            ss_s1   <= 1'b1;
            ss_s2   <= 1'b1;
            ss_d    <= 1'b1;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
            mosi_d  <= 1'b0;
        end else begin
            sclk_s1 <= sclk_i;
            sclk_s2 <= sclk_s1;
            sclk_d  <= sclk_s2;
            ss_s1   <= ss_n_i;
            ss_s2   <= ss_s1;
            ss_d    <= ss_s2;
            mosi_s1 <= mosi_i;
            mosi_s2 <= mosi_s1;
            mosi_d  <= mosi_s2;
        end
    end

    assign sclk_edge  = sclk_s2 ^ sclk_d;
    assign lead_edge  = sclk_edge & (sclk_s2 != cpol_i);
    assign trail_edge = sclk_edge & (sclk_s2 == cpol_i);
    assign ss_fall    = ss_d & ~ss_s2;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (ss_fall) state_nx = SHIFT;
            SHIFT:   if (ss_s2)   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign active    = (state == SHIFT) & ~ss_s2;
    assign start     = (state == IDLE) & ss_fall;
    assign abort     = (state == SHIFT) & ss_s2;
    assign word_done = active & (cnt == CNT_W'(DATA_W));
    assign sample_ev = active & (cpha_i ? trail_edge : lead_edge);
    // cnt==0 blocks the tx shift both on the CPHA=1 first leading edge and on the
    // CPHA=0 trailing edge that follows a word-boundary reload.
    assign shift_ev  = active & (cpha_i ? lead_edge : trail_edge) & (cnt != '0) & ~word_done;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tx_r      <= '0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            cnt       <= '0;
            rx_o      <= '0;
            irq_o     <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            if (tx_load_i) begin
                tx_r <= tx_i;
            end

            if (start) begin
                tx_sr <= tx_r;
                cnt   <= '0;
            end else if (abort) begin
                cnt <= '0;
            end else if (word_done) begin
                rx_o  <= rx_sr;
                tx_sr <= tx_r;
                cnt   <= '0;
            end else begin
                if (sample_ev) begin
                    rx_sr <= dord_i ? {mosi_d, rx_sr[DATA_W-1:1]}
                                    : {rx_sr[DATA_W-2:0], mosi_d};
                    cnt   <= cnt + 1'b1;
                end
                if (shift_ev) begin
                    tx_sr <= dord_i ? {1'b0, tx_sr[DATA_W-1:1]}
                                    : {tx_sr[DATA_W-2:0], 1'b0};
                end
            end

            if (word_done) begin
                irq_o <= 1'b1;
                if (irq_o) begin
                    overrun_o <= 1'b1;
                end
            end else if (ack_i) begin
                irq_o     <= 1'b0;
                overrun_o <= 1'b0;
            end
        end
    end

    assign busy_o    = (state == SHIFT);
    assign miso_en_o = (state == SHIFT);
    assign miso_o    = (state == SHIFT) & (dord_i ? tx_sr[0] : tx_sr[DATA_W-1]);

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a behavioural SPI master drives the pins and
// compares exchanged words and flag behaviour against hand-computed values.
module tb_spi_slave;

    localparam int W    = 8;
    localparam int HALF = 6;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [W-1:0] tx_i;
    logic         tx_load_i;
    logic [W-1:0] rx_o;
    logic         irq_o;
    logic         ack_i;
    logic         overrun_o;
    logic         busy_o;
    logic         cpol_i;
    logic         dord_i;
    logic         cpha_i;
    logic         sclk_i;
    logic         ss_n_i;
    logic         mosi_i;
    logic         miso_o;
    logic         miso_en_o;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] mi, mi1, mi2;
    logic [W-1:0] tx_tab [2];
    logic [W-1:0] mo_tab [2];

    always #5 clk_i = ~clk_i;

    spi_slave #(.DATA_W(W)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .tx_i      (tx_i),
        .tx_load_i (tx_load_i),
        .rx_o      (rx_o),
        .irq_o     (irq_o),
        .ack_i     (ack_i),
        .overrun_o (overrun_o),
        .busy_o    (busy_o),
        .cpol_i    (cpol_i),
        .dord_i    (dord_i),
        .cpha_i    (cpha_i),
        .sclk_i    (sclk_i),
        .ss_n_i    (ss_n_i),
        .mosi_i    (mosi_i),
        .miso_o    (miso_o),
        .miso_en_o (miso_en_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic load_tx(input logic [W-1:0] v);
        @(negedge clk_i);
        tx_i      = v;
        tx_load_i = 1'b1;
        @(negedge clk_i);
        tx_load_i = 1'b0;
    endtask

    task automatic do_ack();
        @(negedge clk_i);
        ack_i = 1'b1;
        @(negedge clk_i);
        ack_i = 1'b0;
    endtask

    task automatic set_mode(input logic pol, input logic pha, input logic ord);
        cpol_i = pol;
        cpha_i = pha;
        dord_i = ord;
        sclk_i = pol;
        wait_clk(HALF);
    endtask

    task automatic select();
        ss_n_i = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic deselect();
        ss_n_i = 1'b1;
        wait_clk(HALF);
    endtask

    // Master side of one word (or nbits of it); lat=1 also checks irq timing
    // around the final leading-edge sample (CPHA=0 only).
    task automatic spi_word(input logic [W-1:0] mo, input int nbits, input bit lat,
                            output logic [W-1:0] rd);
        int bi;
        rd = '0;
        for (int i = 0; i < nbits; i++) begin
            bi = dord_i ? i : W - 1 - i;
            if (!cpha_i) begin
                mosi_i = mo[bi];
                wait_clk(HALF);
                rd[bi] = miso_o;
                sclk_i = ~cpol_i;
                if (lat && i == nbits - 1) begin
                    wait_clk(3);
                    chk("irq_before_latency", irq_o, 1'b0);
                    wait_clk(1);
                    chk("irq_after_latency", irq_o, 1'b1);
                    wait_clk(HALF - 4);
                end else begin
                    wait_clk(HALF);
                end
                sclk_i = cpol_i;
            end else begin
                wait_clk(HALF);
                sclk_i = ~cpol_i;
                mosi_i = mo[bi];
                wait_clk(HALF);
                rd[bi] = miso_o;
                sclk_i = cpol_i;
            end
        end
        wait_clk(HALF);
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; tx_i = '0; tx_load_i = 1'b0; ack_i = 1'b0;
        cpol_i = 1'b0; cpha_i = 1'b0; dord_i = 1'b0;
        sclk_i = 1'b0; ss_n_i = 1'b1; mosi_i = 1'b0;
        wait_clk(3);
        chk("rst_rx", rx_o, 8'h00);
        chk("rst_irq", irq_o, 1'b0);
        chk("rst_ovr", overrun_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_miso_en", miso_en_o, 1'b0);
        chk("rst_miso", miso_o, 1'b0);
        rst_i = 1'b0;
        wait_clk(4);

        // Mode 0 basic exchange with irq latency
        load_tx(8'hA5);
        select();
        chk("m0_busy", busy_o, 1'b1);
        chk("m0_miso_en", miso_en_o, 1'b1);
        chk("m0_first_miso", miso_o, 1'b1);
        spi_word(8'h3C, W, 1'b1, mi);
        chk("m0_master_rd", mi, 8'hA5);
        chk("m0_rx", rx_o, 8'h3C);
        deselect();
        chk("m0_idle_busy", busy_o, 1'b0);
        do_ack();
        chk("m0_ack_irq", irq_o, 1'b0);

        // All four modes, LSB first; second pair is not bit-palindromic
        tx_tab[0] = 8'h81; mo_tab[0] = 8'h7E;
        tx_tab[1] = 8'h1D; mo_tab[1] = 8'hB2;
        for (int m = 0; m < 4; m++) begin
            for (int p = 0; p < 2; p++) begin
                set_mode(m[1], m[0], 1'b1);
                load_tx(tx_tab[p]);
                select();
                spi_word(mo_tab[p], W, 1'b0, mi);
                deselect();
                chk($sformatf("mode%0d_p%0d_master_rd", m, p), mi, tx_tab[p]);
                chk($sformatf("mode%0d_p%0d_rx", m, p), rx_o, mo_tab[p]);
                chk($sformatf("mode%0d_p%0d_irq", m, p), irq_o, 1'b1);
                do_ack();
            end
        end
        set_mode(1'b0, 1'b0, 1'b0);

        // Back-to-back words, tx_r reloaded mid-first-word
        load_tx(8'h9C);
        select();
        fork
            spi_word(8'h11, W, 1'b0, mi1);
            begin
                wait_clk(30);
                load_tx(8'h55);
            end
        join
        chk("b2b_master_rd1", mi1, 8'h9C);
        chk("b2b_rx1", rx_o, 8'h11);
        chk("b2b_irq1", irq_o, 1'b1);
        do_ack();
        chk("b2b_ack_irq", irq_o, 1'b0);
        spi_word(8'h22, W, 1'b0, mi2);
        chk("b2b_master_rd2", mi2, 8'h55);
        chk("b2b_rx2", rx_o, 8'h22);
        chk("b2b_irq2", irq_o, 1'b1);
        chk("b2b_ovr", overrun_o, 1'b0);
        deselect();
        do_ack();

        // Overrun: two words without ack
        select();
        spi_word(8'hA1, W, 1'b0, mi);
        chk("ovr_first_ovr", overrun_o, 1'b0);
        spi_word(8'h5E, W, 1'b0, mi);
        deselect();
        chk("ovr_irq", irq_o, 1'b1);
        chk("ovr_ovr", overrun_o, 1'b1);
        chk("ovr_rx", rx_o, 8'h5E);
        do_ack();
        chk("ovr_ack_irq", irq_o, 1'b0);
        chk("ovr_ack_ovr", overrun_o, 1'b0);

        // Abort after 5 bits, then a clean word
        load_tx(8'h6B);
        select();
        spi_word(8'hF0, 5, 1'b0, mi);
        deselect();
        chk("abort_irq", irq_o, 1'b0);
        chk("abort_rx", rx_o, 8'h5E);
        chk("abort_miso_en", miso_en_o, 1'b0);
        chk("abort_busy", busy_o, 1'b0);
        select();
        spi_word(8'hC3, W, 1'b0, mi);
        deselect();
        chk("post_abort_master_rd", mi, 8'h6B);
        chk("post_abort_rx", rx_o, 8'hC3);
        chk("post_abort_irq", irq_o, 1'b1);

        // Asynchronous reset mid-word (irq still set from the previous word)
        select();
        spi_word(8'hFF, 3, 1'b0, mi);
        #3;
        rst_i = 1'b1;
        #1;
        chk("arst_rx", rx_o, 8'h00);
        chk("arst_irq", irq_o, 1'b0);
        chk("arst_ovr", overrun_o, 1'b0);
        chk("arst_busy", busy_o, 1'b0);
        chk("arst_miso_en", miso_en_o, 1'b0);
        chk("arst_miso", miso_o, 1'b0);
        ss_n_i = 1'b1;
        wait_clk(2);
        rst_i = 1'b0;
        wait_clk(HALF);
        chk("arst_post_irq", irq_o, 1'b0);
        chk("arst_post_busy", busy_o, 1'b0);
        select();
        spi_word(8'h96, W, 1'b0, mi);
        deselect();
        chk("arst_txr_cleared", mi, 8'h00);
        chk("arst_next_rx", rx_o, 8'h96);
        chk("arst_next_irq", irq_o, 1'b1);
        do_ack();
        load_tx(8'h3A);
        select();
        spi_word(8'h4D, W, 1'b0, mi);
        deselect();
        chk("arst_next_master_rd", mi, 8'h3A);
        chk("arst_next_rx2", rx_o, 8'h4D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
